// File: rtl/pulse_train_gen.sv
// Framed pulse-train transmitter: an arm strobe on start, then N pulses on c, then a done flag.
// All outputs are registered from the next state, so no input reaches an output combinationally.
module pulse_train_gen #(
  parameter int CNT_W     = 2,
  parameter int START_CYC = 1,
  parameter int HIGH_CYC  = 1,
  parameter int LOW_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] count,
  output logic             ack,
  output logic             busy,
  output logic             start,
  output logic             c,
  output logic             done
);

  localparam int TMAX = (START_CYC > HIGH_CYC) ?
                        ((START_CYC > LOW_CYC) ? START_CYC : LOW_CYC) :
                        ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_START = TW'(START_CYC - 1);
  localparam logic [TW-1:0] T_HIGH  = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] T_LOW   = TW'(LOW_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, HIGH, LOW, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic             ack_nx;
  logic             tmr_exp;

  assign tmr_exp = (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      tmr   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      start <= 1'b0;
      c     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      tmr   <= tmr_nx;
      ack   <= ack_nx;
      busy  <= (state_nx != IDLE);
      start <= (state_nx == START);
      c     <= (state_nx == HIGH);
      done  <= (state_nx == DONE);
    end
  end

  // ack is only raised on the accepting edge, which yields the first START cycle
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    tmr_nx   = tmr;
    ack_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = START;
          rem_nx   = count;
          tmr_nx   = T_START;
          ack_nx   = 1'b1;
        end
      end
      START, LOW: begin
        if (tmr_exp) begin
          if (rem == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = HIGH;
            tmr_nx   = T_HIGH;
          end
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      HIGH: begin
        if (tmr_exp) begin
          state_nx = LOW;
          tmr_nx   = T_LOW;
          if (rem != '0) rem_nx = rem - CNT_W'(1);
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: table of trains on two parameterisations, expected per-cycle
// outputs derived from the timing formulas, queued at drive time and popped as the DUT runs.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [1:0] count_a, count_b;
  logic       ack_a, busy_a, start_a, c_a, done_a;
  logic       ack_b, busy_b, start_b, c_b, done_b;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  typedef struct {
    bit         sel;
    logic [1:0] n;
    int         exp_d;
    int         exp_p;
    bit         toggle;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(2), .START_CYC(1), .HIGH_CYC(1), .LOW_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .count(count_a),
    .ack(ack_a), .busy(busy_a), .start(start_a), .c(c_a), .done(done_a)
  );

  pulse_train_gen #(.CNT_W(2), .START_CYC(2), .HIGH_CYC(2), .LOW_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .count(count_b),
    .ack(ack_b), .busy(busy_b), .start(start_b), .c(c_b), .done(done_b)
  );

  // Output bundle order is {ack, busy, start, c, done}
  function automatic logic [4:0] get_out(input bit sel);
    return sel ? {ack_b, busy_b, start_b, c_b, done_b}
               : {ack_a, busy_a, start_a, c_a, done_a};
  endfunction

  function automatic logic [4:0] exp_vec(input int k, input int n, input int s,
                                         input int h, input int l);
    int d;
    logic [4:0] v;
    d = s + n * (h + l);
    v[4] = (k == 0);
    v[3] = (k <= d);
    v[2] = (k < s);
    v[1] = (k >= s) && (k < d) && (((k - s) % (h + l)) < h);
    v[0] = (k == d);
    return v;
  endfunction

  task automatic set_req(input bit sel, input logic r, input logic [1:0] n);
    if (sel) begin
      req_b = r; count_b = n;
    end else begin
      req_a = r; count_a = n;
    end
  endtask

  task automatic checkOutput(input string name, input int k,
                             input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got {ack,busy,start,c,done}=%b expected %b",
               name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pushes the whole expected waveform, then raises req for exactly one accepting edge
  task automatic applyStimulus(input bit sel, input logic [1:0] n,
                               input int s, input int h, input int l);
    int d;
    d = s + int'(n) * (h + l);
    for (int k = 0; k <= d + 1; k++) exp_q.push_back(exp_vec(k, int'(n), s, h, l));
    @(negedge clk);
    set_req(sel, 1'b1, n);
    @(posedge clk);
    #1 set_req(sel, 1'b0, n);
  endtask

  task automatic run_train(input vec_t v);
    int s, h, l, d, pulses, done_at;
    logic [4:0] act, exp;
    logic prev_c;
    s = v.sel ? 2 : 1;
    h = v.sel ? 2 : 1;
    l = v.sel ? 3 : 1;
    d = s + int'(v.n) * (h + l);
    pulses = 0;
    done_at = -1;
    prev_c = 1'b0;
    applyStimulus(v.sel, v.n, s, h, l);
    for (int k = 0; k <= d + 1; k++) begin
      @(negedge clk);
      act = get_out(v.sel);
      exp = exp_q.pop_front();
      checkOutput(v.toggle ? "train_toggle" : (v.sel ? "train_b" : "train_a"), k, act, exp);
      if (act[1] && !prev_c) pulses++;
      prev_c = act[1];
      if (act[0]) done_at = k;
      if (v.toggle && k == 1) set_req(v.sel, 1'b1, 2'd1);
      if (v.toggle && k == 3) set_req(v.sel, 1'b0, 2'd0);
    end
    check_int("done_cycle", done_at, v.exp_d);
    check_int("pulse_count", pulses, v.exp_p);
  endtask

  initial begin
    int acks;
    logic [4:0] act;

    vecs[0] = '{sel: 1'b0, n: 2'd3, exp_d: 7,  exp_p: 3, toggle: 1'b0};
    vecs[1] = '{sel: 1'b0, n: 2'd0, exp_d: 1,  exp_p: 0, toggle: 1'b0};
    vecs[2] = '{sel: 1'b0, n: 2'd1, exp_d: 3,  exp_p: 1, toggle: 1'b0};
    vecs[3] = '{sel: 1'b1, n: 2'd2, exp_d: 12, exp_p: 2, toggle: 1'b0};
    vecs[4] = '{sel: 1'b0, n: 2'd3, exp_d: 7,  exp_p: 3, toggle: 1'b1};
    vecs[5] = '{sel: 1'b0, n: 2'd2, exp_d: 5,  exp_p: 2, toggle: 1'b0};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 2'd0);
    set_req(1'b1, 1'b0, 2'd0);
    #3;
    checkOutput("reset_state_a", 0, get_out(1'b0), 5'b00000);
    checkOutput("reset_state_b", 0, get_out(1'b1), 5'b00000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_train(vecs[i]);

    // Asynchronous reset while the first pulse is high
    applyStimulus(1'b0, 2'd3, 1, 1, 1);
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      checkOutput("pre_reset", k, get_out(1'b0), exp_q.pop_front());
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 1, get_out(1'b0), 5'b00000);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_idle", 0, get_out(1'b0), 5'b00000);
    run_train(vecs[2]);

    // req held high with count=1: a new train every 5 cycles with one idle gap
    acks = 0;
    for (int k = 0; k < 15; k++) exp_q.push_back(exp_vec(k % 5, 1, 1, 1, 1));
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'd1);
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      act = get_out(1'b0);
      checkOutput("back_to_back", k, act, exp_q.pop_front());
      if (act[4]) acks++;
      if (k == 14) set_req(1'b0, 1'b0, 2'd0);
    end
    check_int("back_to_back_acks", acks, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
